// File: rtl/data_dly_cfg.sv
// data_dly_cfg: runtime-length delay line; holds a valid/ready stream until cfg_len items
// have accumulated, then releases them in order, with flush/drain control and occupancy status.
`default_nettype none

module data_dly_cfg #(
  parameter int MAX_LEN = 8,
  parameter int W_DIN   = 16,
  parameter int W_LEN   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_DIN-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W_DIN-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic [W_LEN-1:0] cfg_len,
  input  logic             flush,
  output logic [W_LEN-1:0] level,
  output logic             primed
);

  localparam int               W_PTR = $clog2(MAX_LEN);
  localparam logic [W_LEN-1:0] FULL  = W_LEN'(MAX_LEN);
  localparam logic [W_LEN-1:0] ONE   = W_LEN'(1);

  logic [W_DIN-1:0] mem [MAX_LEN];

  logic [W_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_LEN-1:0] level_q, level_d;
  logic [W_LEN-1:0] len_q, len_d;
  logic             primed_q, primed_d;
  logic [W_LEN-1:0] len_clamp;
  logic             push, pop;

  // ready is forced low while reset is asserted, even though the buffer is empty
  assign din_ready  = rst && (level_q != FULL);
  assign dout_valid = (level_q != '0) && (primed_q || flush);
  assign dout_data  = mem[rd_ptr_q];
  assign level      = level_q;
  assign primed     = primed_q;

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = ONE;
    end else if (cfg_len > FULL) begin
      len_clamp = FULL;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    len_d    = len_q;
    primed_d = primed_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + W_PTR'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + W_PTR'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase

    // threshold only changes while idle and empty so an in-flight window is never resized
    if ((level_q == '0) && !push) begin
      len_d = len_clamp;
    end

    if (level_d == '0) begin
      primed_d = 1'b0;
    end else if (level_d >= len_q) begin
      primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      len_q    <= ONE;
      primed_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      len_q    <= len_d;
      primed_q <= primed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= din_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_dly_cfg.sv
// tb_data_dly_cfg: directed self-checking bench for data_dly_cfg with hand-computed expectations.
`default_nettype none

module tb_data_dly_cfg;

  localparam int MAX_LEN = 8;
  localparam int W_DIN   = 16;
  localparam int W_LEN   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W_DIN-1:0] din_data = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [W_DIN-1:0] dout_data;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [W_LEN-1:0] cfg_len = '0;
  logic             flush = 1'b0;
  logic [W_LEN-1:0] level;
  logic             primed;

  int n_chk  = 0;
  int n_fail = 0;

  data_dly_cfg #(.MAX_LEN(MAX_LEN), .W_DIN(W_DIN), .W_LEN(W_LEN)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cfg_len(cfg_len), .flush(flush), .level(level), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_items(input logic [W_DIN-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din_data  = base + W_DIN'(i);
      tick();
    end
    din_valid = 1'b0;
    #1;
  endtask

  task automatic drain(input logic [W_DIN-1:0] base, input int n, input string tag);
    dout_ready = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      chk_eq({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk_eq({tag, "_data"}, 32'(dout_data), 32'(base + W_DIN'(i)));
      tick();
    end
    chk_eq({tag, "_empty"}, 32'(level), 32'd0);
  endtask

  initial begin
    // reset state
    #1 rst = 1'b0;
    #2;
    chk_eq("rst_level", 32'(level), 32'd0);
    chk_eq("rst_primed", 32'(primed), 32'd0);
    chk_eq("rst_dvalid", 32'(dout_valid), 32'd0);
    chk_eq("rst_dready", 32'(din_ready), 32'd0);
    #19 rst = 1'b1;

    // priming with cfg_len=4
    cfg_len = 4'd4;
    tick();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din_data  = 16'h0011 * 16'(i + 1);
      #1;
      chk_eq("prime_hold", 32'(dout_valid), 32'd0);
      tick();
    end
    din_valid = 1'b0;
    #1;
    chk_eq("prime_level", 32'(level), 32'd4);
    chk_eq("prime_primed", 32'(primed), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_eq("prime_out", 32'(dout_data), 32'h11 * 32'(i + 1));
      chk_eq("prime_ov", 32'(dout_valid), 32'd1);
      tick();
    end
    chk_eq("prime_end_level", 32'(level), 32'd0);
    chk_eq("prime_end_primed", 32'(primed), 32'd0);
    chk_eq("prime_end_valid", 32'(dout_valid), 32'd0);

    // full buffer, backpressure, pointer wrap
    cfg_len = 4'd8;
    dout_ready = 1'b0;
    tick();
    push_items(16'h0080, 8);
    chk_eq("full_ready", 32'(din_ready), 32'd0);
    chk_eq("full_level", 32'(level), 32'd8);
    chk_eq("full_primed", 32'(primed), 32'd1);
    dout_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      din_valid = (k <= 7);
      din_data  = (k == 0) ? 16'h0090 : 16'h0090 + 16'(k - 1);
      #1;
      if (k <= 7) chk_eq("bp_ready", 32'(din_ready), (k == 0) ? 32'd0 : 32'd1);
      chk_eq("bp_level", 32'(level), (k == 0) ? 32'd8 : (k <= 8) ? 32'd7 : 32'(15 - k));
      chk_eq("bp_data", 32'(dout_data), (k < 8) ? 32'h80 + 32'(k) : 32'h90 + 32'(k - 8));
      tick();
    end
    din_valid = 1'b0;
    #1;
    chk_eq("bp_empty", 32'(level), 32'd0);

    // flush without priming
    cfg_len = 4'd6;
    tick();
    push_items(16'h00A0, 3);
    chk_eq("fl_level", 32'(level), 32'd3);
    chk_eq("fl_hold", 32'(dout_valid), 32'd0);
    flush = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_eq("fl_data", 32'(dout_data), 32'hA0 + 32'(i));
      chk_eq("fl_primed", 32'(primed), 32'd0);
      tick();
    end
    chk_eq("fl_empty", 32'(level), 32'd0);
    chk_eq("fl_empty_valid", 32'(dout_valid), 32'd0);
    flush = 1'b0;
    tick();
    push_items(16'h00B0, 2);
    tick();
    chk_eq("fl_stall_valid", 32'(dout_valid), 32'd0);
    chk_eq("fl_stall_level", 32'(level), 32'd2);
    flush = 1'b1;
    drain(16'h00B0, 2, "fl_drain");
    flush = 1'b0;

    // cfg_len=0 behaves as 1
    cfg_len = 4'd0;
    tick();
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din_valid = (k < 3);
      din_data  = 16'h00C0 + 16'(k);
      #1;
      chk_eq("l0_valid", 32'(dout_valid), (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 1) chk_eq("l0_data", 32'(dout_data), 32'hC0 + 32'(k - 1));
      tick();
    end
    din_valid = 1'b0;
    #1;
    chk_eq("l0_empty", 32'(level), 32'd0);

    // cfg_len=15 clamps to 8
    cfg_len = 4'd15;
    dout_ready = 1'b0;
    tick();
    push_items(16'h00D0, 7);
    chk_eq("l15_primed7", 32'(primed), 32'd0);
    push_items(16'h00D7, 1);
    chk_eq("l15_primed8", 32'(primed), 32'd1);
    chk_eq("l15_level", 32'(level), 32'd8);
    drain(16'h00D0, 8, "l15_drain");

    // cfg_len change while occupied is ignored
    cfg_len = 4'd4;
    dout_ready = 1'b0;
    tick();
    push_items(16'h00E0, 3);
    cfg_len = 4'd2;
    tick();
    tick();
    chk_eq("chg_hold", 32'(dout_valid), 32'd0);
    chk_eq("chg_primed", 32'(primed), 32'd0);
    push_items(16'h00E3, 1);
    chk_eq("chg_primed4", 32'(primed), 32'd1);
    drain(16'h00E0, 4, "chg_drain");
    dout_ready = 1'b0;
    tick();
    push_items(16'h00F0, 1);
    chk_eq("chg_new1", 32'(primed), 32'd0);
    push_items(16'h00F1, 1);
    chk_eq("chg_new2", 32'(primed), 32'd1);
    chk_eq("chg_new2_valid", 32'(dout_valid), 32'd1);
    drain(16'h00F0, 2, "chg_new_drain");

    // asynchronous reset mid-operation
    cfg_len = 4'd4;
    dout_ready = 1'b0;
    tick();
    push_items(16'h0050, 5);
    chk_eq("ar_pre_level", 32'(level), 32'd5);
    chk_eq("ar_pre_primed", 32'(primed), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_eq("ar_level", 32'(level), 32'd0);
    chk_eq("ar_primed", 32'(primed), 32'd0);
    chk_eq("ar_dvalid", 32'(dout_valid), 32'd0);
    chk_eq("ar_dready", 32'(din_ready), 32'd0);
    cfg_len = 4'd1;
    #1 rst = 1'b1;
    tick();
    chk_eq("ar_post_valid", 32'(dout_valid), 32'd0);
    chk_eq("ar_post_level", 32'(level), 32'd0);
    push_items(16'h0060, 1);
    chk_eq("ar_fresh_level", 32'(level), 32'd1);
    drain(16'h0060, 1, "ar_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
